// File: rtl/weight_az_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : weight_az_fsm
//  Purpose  : Bandwidth-expands an LP filter, ap[i] = a[i] * gamma^i, in Q15.
//             Reads gamma from GAMMA_ADDR and a[0..M] from A_BASE on the
//             shared scratch-memory bus. Writes ap[0..M] to AP_BASE, then
//             raises done.
//  Ports    : clk, reset      - clock and synchronous active-high reset
//             start           - begins one computation when idle or done
//             memIn           - read data, one cycle after memReadAddr
//             memReadAddr     - read address
//             memWriteAddr    - write address
//             memOut          - write data {16'd0, ap[i]}
//             memWriteEn      - one-cycle write strobe per ap word
//             satFlag         - sticky saturation indicator (optional)
//             done            - high from completion until next start
//  Options  : WEIGHT_AZ_SAT_FLAG_EN adds the satFlag output port.
//  Revision : 1.0 - initial release
// ============================================================================
module weight_az_fsm #(
  parameter int unsigned M          = 10,
  parameter logic [10:0] GAMMA_ADDR = 11'd0,
  parameter logic [10:0] A_BASE     = 11'd32,
  parameter logic [10:0] AP_BASE    = 11'd64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] memIn,
  output logic [10:0] memReadAddr,
  output logic [10:0] memWriteAddr,
  output logic [31:0] memOut,
  output logic        memWriteEn,
`ifdef WEIGHT_AZ_SAT_FLAG_EN
  output logic        satFlag,
`endif
  output logic        done
);

  localparam int unsigned c_IDX_W = (M < 1) ? 1 : $clog2(M + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_G = 3'd1,
    S_LD_G = 3'd2,
    S_RD_A = 3'd3,
    S_WR   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [15:0]          r_gamma;
  logic [15:0]          r_fac;
  logic [c_IDX_W-1:0]   r_idx;
  logic                 r_done;

  logic [15:0]          w_a;
  logic                 w_first;
  logic                 w_last;
  logic [10:0]          w_idx_addr;

  // ap path: round(L_mult(a, fac))
  logic signed [31:0]   w_ap_p;
  logic                 w_ap_msat;
  logic [31:0]          w_ap_l;
  logic [31:0]          w_ap_s;
  logic                 w_ap_asat;
  logic [15:0]          w_ap_r;
  logic [15:0]          w_ap;

  // fac path: round(L_mult(fac, gamma))
  logic signed [31:0]   w_fac_p;
  logic                 w_fac_msat;
  logic [31:0]          w_fac_l;
  logic [31:0]          w_fac_s;
  logic                 w_fac_asat;
  logic [15:0]          w_fac_r;

  logic                 w_sat;
  logic                 w_unused;

  assign w_a        = memIn[15:0];
  assign w_first    = (r_idx == '0);
  assign w_last     = (r_idx == c_IDX_W'(M));
  assign w_idx_addr = 11'(r_idx);

  // The raw signed product never needs bit 31 except for -1 * -1, which is
  // caught separately and forced to the positive saturation value.
  assign w_ap_p    = 32'(signed'(w_a)) * 32'(signed'(r_fac));
  assign w_ap_msat = (w_a == 16'h8000) && (r_fac == 16'h8000);
  assign w_ap_l    = w_ap_msat ? 32'h7FFF_FFFF : {w_ap_p[30:0], 1'b0};
  assign w_ap_s    = w_ap_l + 32'h0000_8000;
  // Adding a positive constant can only overflow from positive to negative.
  assign w_ap_asat = ~w_ap_l[31] & w_ap_s[31];
  assign w_ap_r    = w_ap_asat ? 16'h7FFF : w_ap_s[31:16];
  assign w_ap      = w_first ? w_a : w_ap_r;

  assign w_fac_p    = 32'(signed'(r_fac)) * 32'(signed'(r_gamma));
  assign w_fac_msat = (r_fac == 16'h8000) && (r_gamma == 16'h8000);
  assign w_fac_l    = w_fac_msat ? 32'h7FFF_FFFF : {w_fac_p[30:0], 1'b0};
  assign w_fac_s    = w_fac_l + 32'h0000_8000;
  assign w_fac_asat = ~w_fac_l[31] & w_fac_s[31];
  assign w_fac_r    = w_fac_asat ? 16'h7FFF : w_fac_s[31:16];

  // Neither product is evaluated for i = 0, so no saturation can occur there.
  assign w_sat = ~w_first & (w_ap_msat | w_ap_asat | w_fac_msat | w_fac_asat);

  assign w_unused = ^{memIn[31:16], w_ap_p[31], w_ap_s[15:0],
                      w_fac_p[31], w_fac_s[15:0]};

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_gamma <= '0;
      r_fac   <= '0;
      r_idx   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_done <= 1'b0;
          end else if (r_state == S_DONE) begin
            r_done <= 1'b1;
          end
        end
        S_LD_G: begin
          r_gamma <= w_a;
          r_fac   <= w_a;
          r_idx   <= '0;
        end
        S_WR: begin
          // fac holds gamma^i while ap[i] is formed; advance it afterwards.
          if (!w_first) begin
            r_fac <= w_fac_r;
          end
          if (!w_last) begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Next state and bus outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    memReadAddr  = '0;
    memWriteAddr = '0;
    memOut       = '0;
    memWriteEn   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_next_state = S_RD_G;
        end
      end
      S_RD_G: begin
        memReadAddr  = GAMMA_ADDR;
        w_next_state = S_LD_G;
      end
      S_LD_G: begin
        memReadAddr  = A_BASE;
        w_next_state = S_RD_A;
      end
      S_RD_A: begin
        memReadAddr  = A_BASE + w_idx_addr;
        w_next_state = S_WR;
      end
      S_WR: begin
        memWriteAddr = AP_BASE + w_idx_addr;
        memOut       = {16'd0, w_ap};
        memWriteEn   = 1'b1;
        w_next_state = w_last ? S_DONE : S_RD_A;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign done = r_done;

`ifdef WEIGHT_AZ_SAT_FLAG_EN
  logic r_sat;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sat <= 1'b0;
    end else if ((r_state == S_IDLE || r_state == S_DONE) && start) begin
      r_sat <= 1'b0;
    end else if (r_state == S_WR && w_sat) begin
      r_sat <= 1'b1;
    end
  end

  assign satFlag = r_sat;
`else
  logic w_unused_sat;
  assign w_unused_sat = w_sat;
`endif

endmodule
`default_nettype wire

// File: doc/weight_az_fsm.md
Name: weight_az_fsm

Overview:
- Reader/consumer of the perceptual-variation gamma outputs.
- After percVar has written gamma into scratch memory, this FSM reads one gamma word and the LP coefficients a[0..M], and computes the bandwidth-expanded filter ap[i] = a[i]*gamma^i (G.729 Weight_Az).
- Writes ap[0..M] back to scratch memory, then raises done.
- Sits on the shared 11-bit-address / 32-bit-data memory bus, behind the same memory mux as the other perceptual-adaptation blocks.

Parameters:
- M, 10, LP order; the block computes M+1 outputs.
- GAMMA_ADDR, 11'd0, memory address of the gamma word; the system instantiates one copy with PERC_VAR_GAMMA1 and one with PERC_VAR_GAMMA2.
- A_BASE, 11'd32, base address of a[0..M].
- AP_BASE, 11'd64, base address of ap[0..M].

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- reset, input, 1, synchronous, active-high.
- start, input, 1, starts one computation when sampled high in IDLE.
- memIn, input, 32, read data; valid the cycle after memReadAddr is presented; only bits [15:0] are used.
- memReadAddr, output, 11, read address.
- memWriteAddr, output, 11, write address.
- memOut, output, 32, write data: {16'd0, ap[i]}.
- memWriteEn, output, 1, write strobe, one cycle per word.
- done, output, 1, high from completion until the next accepted start.

Behaviour:
- Reset (sampled at clk edge): state=IDLE; memReadAddr=0, memWriteAddr=0, memOut=0, memWriteEn=0, done=0; internal fac and index cleared.
- Reset has priority over everything. Reset mid-operation aborts at the next edge; no further writes occur.
- States and transitions:
  - IDLE: on start go to RD_G; done cleared at the same edge.
  - RD_G: memReadAddr=GAMMA_ADDR. Next state LD_G.
  - LD_G: gamma=memIn[15:0]; fac=gamma; i=0; memReadAddr=A_BASE. Next state RD_A.
  - RD_A: memReadAddr=A_BASE+i; memWriteEn=0. Next state WR.
  - WR: a=memIn[15:0]. Compute ap:
    - i=0: ap=a.
    - else: ap=round(L_mult(a,fac)).
    - Drive memWriteAddr=AP_BASE+i, memOut={16'd0,ap}, memWriteEn=1 for this cycle.
    - If i>=1: fac=round(L_mult(fac,gamma)).
    - If i==M: next state DONE; else i=i+1 and next state RD_A.
  - DONE: done=1, memWriteEn=0; stay until start, then behave as IDLE+start.
- Arithmetic (16-bit two's complement, Q15):
  - L_mult(x,y) = (x*y)<<1, 32-bit; 0x8000*0x8000 saturates to 0x7FFFFFFF.
  - round(L) = upper 16 bits of L_add(L,0x00008000), with L_add saturating at 0x7FFFFFFF / 0x80000000.
- Latency:
  - Start sampled at edge 0; done is high after edge 2+2*(M+1)+1 = 25 for M=10.
  - Exactly M+1 write strobes, in ascending address order.
- start asserted while busy (any state except IDLE/DONE) is ignored.
- memWriteEn is never high outside WR.
- Addresses wrap modulo 2^11 if base+M overflows; this is not checked.

Optional Feature:
- Macro WEIGHT_AZ_SAT_FLAG_EN.
- When defined: adds output port satFlag (1 bit).
  - Cleared by reset and by an accepted start.
  - Set (sticky) in any WR cycle in which L_mult or L_add saturates, for either the ap or the fac computation.
  - Readable together with done.
- When undefined: the port and its logic are absent; datapath results are identical in both builds.

Test Plan:
- gamma=0x4000, a[0..10]=0x1000, start pulse -> ap[i]=0x1000>>i (0x1000,0x0800,…,0x0004); 11 writes to AP_BASE..AP_BASE+10; done high 25 cycles after start.
- gamma=0x7852 (0.94) with ITU tame vector a[] -> ap matches the C Weight_Az reference word for word, for 60 frames back-to-back, re-asserting start after each done.
- gamma=0x8000, a[1]=0x8000 -> ap[1]=0x7FFF (saturated). With WEIGHT_AZ_SAT_FLAG_EN defined, satFlag=1; with gamma=0x4000 it stays 0.
- Reset asserted for one cycle during the write of ap[5] -> no writes after reset; outputs at reset values; done=0; a following start completes normally.
- start held high for the whole run, plus an extra start pulse mid-operation -> exactly 11 writes per accepted start; memory contents unaffected by the ignored pulse.
